// File: rtl/irq_request_latch_if.sv
// Signal bundle between the request latch, the CPU-side handshake and the external
// priority encoder. The latch itself uses the master view; the environment uses the slave view.
interface irq_request_latch_if;
   logic [7:0] irq_in;
   logic [7:0] edge_mode;
   logic [7:0] mask;
   logic [7:0] pend_d;
   logic [2:0] enc_y;
   logic       enc_valid;
   logic       irq_req;
   logic [2:0] irq_id;
   logic       irq_ack;
   logic       eoi;
   logic       in_service;

   modport master (
      input  irq_in,
      input  edge_mode,
      input  mask,
      input  enc_y,
      input  enc_valid,
      input  irq_ack,
      input  eoi,
      output pend_d,
      output irq_req,
      output irq_id,
      output in_service
   );

   modport slave (
      output irq_in,
      output edge_mode,
      output mask,
      output enc_y,
      output enc_valid,
      output irq_ack,
      output eoi,
      input  pend_d,
      input  irq_req,
      input  irq_id,
      input  in_service
   );
endinterface

// File: rtl/irq_request_latch.sv
// Interrupt request front-end: synchronises 8 request lines, latches edge/level events,
// feeds the masked pending vector to an 8-to-3 encoder and runs the CPU req/ack/eoi handshake.
module irq_request_latch #(
   parameter int unsigned SYNC_STAGES = 2  // legal 2..3
) (
   input logic                 clk,
   input logic                 rst_n,
   irq_request_latch_if.master bus
);

   localparam int unsigned N = 8;

   typedef enum logic [1:0] {StIdle, StReq, StSvc} state_e;

   logic [SYNC_STAGES-1:0][N-1:0] sync_q;
   logic [N-1:0]                  sync_s;
   logic [N-1:0]                  prev_q;
   logic [N-1:0]                  edge_set;
   logic [N-1:0]                  pending_q, pending_d;

   state_e     state_q, state_d;
   logic       irq_req_q, irq_req_d;
   logic [2:0] irq_id_q, irq_id_d;
   logic       in_service_q, in_service_d;
   logic       ack_clr;
   logic       withdraw;

   // ---------------------------------------------------------------------------------------
   // Synchroniser, edge detection and pending bits
   // ---------------------------------------------------------------------------------------
   assign sync_s   = sync_q[SYNC_STAGES-1];
   assign edge_set = sync_s & ~prev_q;
   assign ack_clr  = (state_q == StReq) && bus.irq_ack;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q    <= '0;
         prev_q    <= '0;
         pending_q <= '0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.irq_in};
         prev_q    <= sync_s;
         pending_q <= pending_d;
      end
   end

   // In edge mode a fresh edge beats an ack-clear in the same cycle so no event is lost.
   always_comb begin
      pending_d = '0;
      for (int i = 0; i < N; i++) begin
         if (bus.edge_mode[i]) begin
            pending_d[i] = edge_set[i] |
                           (pending_q[i] & ~(ack_clr && (irq_id_q == 3'(i))));
         end else begin
            pending_d[i] = sync_s[i];
         end
      end
   end

   assign bus.pend_d = pending_q & ~bus.mask & {N{state_q == StIdle}};

   // ---------------------------------------------------------------------------------------
   // Handshake FSM: state register, next-state logic, registered-output logic
   // ---------------------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         irq_req_q    <= 1'b0;
         irq_id_q     <= 3'd0;
         in_service_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         irq_req_q    <= irq_req_d;
         irq_id_q     <= irq_id_d;
         in_service_q <= in_service_d;
      end
   end

   assign withdraw = ~pending_q[irq_id_q] | bus.mask[irq_id_q];

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (bus.enc_valid) state_d = StReq;
         end
         StReq: begin
            if (bus.irq_ack)   state_d = StSvc;
            else if (withdraw) state_d = StIdle;
         end
         StSvc: begin
            if (bus.eoi) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // irq_id only moves when a new request is launched, so it holds through REQ/SVC and IDLE.
   always_comb begin
      irq_req_d    = (state_d == StReq);
      in_service_d = (state_d == StSvc);
      irq_id_d     = irq_id_q;
      if (state_q == StIdle && bus.enc_valid) irq_id_d = bus.enc_y;
   end

   assign bus.irq_req    = irq_req_q;
   assign bus.irq_id     = irq_id_q;
   assign bus.in_service = in_service_q;

   // ---------------------------------------------------------------------------------------
   // Sanity properties
   // ---------------------------------------------------------------------------------------
   a_req_svc_excl: assert property (@(posedge clk) disable iff (!rst_n)
      !(irq_req_q && in_service_q));

   a_id_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q != StIdle) |=> $stable(irq_id_q));

   a_pend_gated: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q != StIdle) |-> (bus.pend_d == '0));

endmodule

// File: tb/tb_irq_request_latch.sv
// Scoreboard bench for irq_request_latch with a behavioural 8-to-3 priority encoder in the loop.
module tb_irq_request_latch;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   irq_request_latch_if bus ();

   irq_request_latch #(.SYNC_STAGES(2)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Encoder model: highest set bit of pend_d wins.
   always_comb begin
      bus.enc_valid = |bus.pend_d;
      bus.enc_y     = 3'd0;
      for (int i = 0; i < 8; i++) if (bus.pend_d[i]) bus.enc_y = 3'(i);
   end

   int         n_checks = 0;
   int         n_errs = 0;
   logic [2:0] exp_q[$];
   logic [2:0] exp_id;
   logic       req_prev = 1'b0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
      n_checks++;
      if (act !== req) begin
         n_errs++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_req(input string name);
      int n = 0;
      while (bus.irq_req !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_req_timeout"}, {7'd0, bus.irq_req}, 8'd1);
   endtask

   task automatic ack_pulse();
      bus.irq_ack = 1'b1;
      @(negedge clk);
      bus.irq_ack = 1'b0;
   endtask

   task automatic eoi_pulse();
      bus.eoi = 1'b1;
      @(negedge clk);
      bus.eoi = 1'b0;
   endtask

   task automatic service(input string name);
      wait_req(name);
      ack_pulse();
      eoi_pulse();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] pat;
      bus.irq_in    = 8'h00;
      bus.edge_mode = 8'h00;
      bus.mask      = 8'h00;
      bus.irq_ack   = 1'b0;
      bus.eoi       = 1'b0;

      // Monitor: every rising irq_req is matched against the next expected id.
      fork
         forever begin
            @(negedge clk);
            if (!rst_n) begin
               req_prev = 1'b0;
            end else begin
               if (bus.irq_req && !req_prev) begin
                  n_checks++;
                  if (exp_q.size() == 0) begin
                     n_errs++;
                     $display("FAIL mon_unexpected: got request id %0d required none", bus.irq_id);
                  end else begin
                     exp_id = exp_q.pop_front();
                     if (bus.irq_id !== exp_id) begin
                        n_errs++;
                        $display("FAIL mon_id: got %0d required %0d", bus.irq_id, exp_id);
                     end
                  end
               end
               req_prev = bus.irq_req;
            end
         end
      join_none

      // T1: reset state, then asynchronous reset in the middle of REQ
      tick(3);
      chk("rst_req", {7'd0, bus.irq_req}, 8'd0);
      chk("rst_svc", {7'd0, bus.in_service}, 8'd0);
      chk("rst_pend", bus.pend_d, 8'h00);
      chk("rst_id", {5'd0, bus.irq_id}, 8'd0);
      rst_n = 1'b1;
      bus.irq_in = 8'hFF;
      exp_q.push_back(3'd7);
      wait_req("t1");
      tick(1);
      rst_n = 1'b0;
      #1;
      chk("t1_async_req", {7'd0, bus.irq_req}, 8'd0);
      chk("t1_async_svc", {7'd0, bus.in_service}, 8'd0);
      chk("t1_async_pend", bus.pend_d, 8'h00);
      chk("t1_async_id", {5'd0, bus.irq_id}, 8'd0);
      bus.irq_in = 8'h00;
      tick(3);
      rst_n = 1'b1;
      tick(3);

      // T2: edge latency and handshake
      bus.edge_mode = 8'hFF;
      exp_q.push_back(3'd2);
      bus.irq_in = 8'h04;
      tick(2);
      chk("t2_pend_clk2", bus.pend_d, 8'h00);
      tick(1);
      chk("t2_pend_clk3", bus.pend_d, 8'h04);
      chk("t2_req_clk3", {7'd0, bus.irq_req}, 8'd0);
      tick(1);
      chk("t2_req_clk4", {7'd0, bus.irq_req}, 8'd1);
      chk("t2_id_clk4", {5'd0, bus.irq_id}, 8'd2);
      ack_pulse();
      chk("t2_svc", {7'd0, bus.in_service}, 8'd1);
      chk("t2_req_after_ack", {7'd0, bus.irq_req}, 8'd0);
      bus.irq_ack = 1'b1;  // ack in SVC must be ignored
      tick(1);
      bus.irq_ack = 1'b0;
      chk("t2_svc_hold", {7'd0, bus.in_service}, 8'd1);
      eoi_pulse();
      chk("t2_svc_eoi", {7'd0, bus.in_service}, 8'd0);
      chk("t2_pend_cleared", bus.pend_d, 8'h00);
      tick(2);
      chk("t2_no_rereq", {7'd0, bus.irq_req}, 8'd0);
      bus.irq_in = 8'h00;
      tick(3);

      // T3: priority between two simultaneous edges
      exp_q.push_back(3'd7);
      exp_q.push_back(3'd0);
      bus.irq_in = 8'h81;
      service("t3a");
      service("t3b");
      bus.irq_in = 8'h00;
      tick(3);

      // T4: new edge on the line being acked in the same cycle
      exp_q.push_back(3'd5);
      bus.irq_in = 8'h20;
      wait_req("t4a");
      bus.irq_in = 8'h00;
      tick(4);
      bus.irq_in = 8'h20;
      tick(2);
      bus.irq_ack = 1'b1;
      tick(1);
      bus.irq_ack = 1'b0;
      chk("t4_svc", {7'd0, bus.in_service}, 8'd1);
      exp_q.push_back(3'd5);
      eoi_pulse();
      wait_req("t4b");
      ack_pulse();
      eoi_pulse();
      bus.irq_in = 8'h00;
      tick(3);

      // T5: level withdraw, then masked edge surfacing on unmask
      bus.edge_mode = 8'h00;
      exp_q.push_back(3'd3);
      bus.irq_in = 8'h08;
      wait_req("t5a");
      tick(1);
      bus.irq_in = 8'h00;
      tick(6);
      chk("t5_withdraw_req", {7'd0, bus.irq_req}, 8'd0);
      chk("t5_withdraw_svc", {7'd0, bus.in_service}, 8'd0);
      chk("t5_id_hold", {5'd0, bus.irq_id}, 8'd3);
      bus.edge_mode = 8'hFF;
      bus.mask = 8'h02;
      bus.irq_in = 8'h02;
      tick(6);
      chk("t5_masked_req", {7'd0, bus.irq_req}, 8'd0);
      chk("t5_masked_pend", bus.pend_d, 8'h00);
      exp_q.push_back(3'd1);
      bus.mask = 8'h00;
      #1;
      chk("t5_unmask_pend", bus.pend_d, 8'h02);
      service("t5b");
      bus.irq_in = 8'h00;
      tick(3);

      // T6: sweep all patterns, each bit serviced once in descending order
      for (int v = 1; v < 256; v++) begin
         pat = 8'(v);
         for (int b = 7; b >= 0; b--) if (pat[b]) exp_q.push_back(3'(b));
         bus.irq_in = pat;
         for (int k = 0; k < $countones(pat); k++) service("t6");
         tick(2);
         chk("t6_no_extra", {7'd0, bus.irq_req}, 8'd0);
         bus.irq_in = 8'h00;
         tick(3);
      end

      tick(4);
      chk("sb_empty", 8'(exp_q.size()), 8'd0);
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
